// File: rtl/single_digit_decimal_adder.sv
// Single-digit BCD adder with valid qualifier and optional output register.
// Optional feature: define BCD_INPUT_CHECK_EN to flag non-BCD operands on err.
// Without it, err is tied low and illegal operands use the raw correction rule.
module single_digit_decimal_adder #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       out_valid,
    output logic [3:0] s,
    output logic       cout,
    output logic       err
);

    logic [4:0] raw_sum;
    logic [3:0] corr_sum;
    logic [3:0] s_d;
    logic       cout_d;
    logic       err_d;

    // Binary add of both digits and carry, then +6 correction when the sum exceeds 9
    always_comb begin
        raw_sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        corr_sum = raw_sum[3:0] + 4'd6;
        s_d      = raw_sum[3:0];
        cout_d   = 1'b0;
        err_d    = 1'b0;
        if (raw_sum > 5'd9) begin
            s_d    = corr_sum;
            cout_d = 1'b1;
        end
`ifdef BCD_INPUT_CHECK_EN
        if (in_valid && ((a > 4'd9) || (b > 4'd9))) begin
            s_d    = '0;
            cout_d = 1'b0;
            err_d  = 1'b1;
        end
`endif
    end

    generate
        if (REG_OUT) begin : g_reg
            logic       out_valid_q;
            logic [3:0] s_q;
            logic       cout_q;
            logic       err_q;

            // Result register: valid follows in_valid, data loads only on valid input
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    s_q         <= '0;
                    cout_q      <= 1'b0;
                    err_q       <= 1'b0;
                end else begin
                    out_valid_q <= in_valid;
                    if (in_valid) begin
                        s_q    <= s_d;
                        cout_q <= cout_d;
                        err_q  <= err_d;
                    end
                end
            end

            assign out_valid = out_valid_q;
            assign s         = s_q;
            assign cout      = cout_q;
            assign err       = err_q;
        end else begin : g_comb
            // Clock and reset have no function in the combinational build
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign out_valid = in_valid;
            assign s         = s_d;
            assign cout      = cout_d;
            assign err       = err_d;
        end
    endgenerate

endmodule

// File: tb/tb_single_digit_decimal_adder.sv
// Scoreboard bench for single_digit_decimal_adder (REG_OUT=1).
// Directed vectors with hand-computed results; a monitor on the falling edge
// pops expectations whenever out_valid is high and checks hold behaviour otherwise.
module tb_single_digit_decimal_adder;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] es;
        logic       ec;
        logic       ee;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       out_valid;
    logic [3:0] s;
    logic       cout;
    logic       err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    vec_t exp_q[$];
    logic mon_en = 1'b0;
    logic iv_d;
    logic [3:0] last_s;
    logic last_c;
    logic last_e;

    single_digit_decimal_adder #(.REG_OUT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .s(s), .cout(cout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected valid pipeline: in_valid delayed one cycle, cleared by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) iv_d <= 1'b0;
        else        iv_d <= in_valid;
    end

    // Monitor: compare popped expectation on valid output, otherwise check hold
    always @(negedge clk) begin
        if (!rst_n) begin
            last_s = '0;
            last_c = 1'b0;
            last_e = 1'b0;
        end else if (mon_en) begin
            chk("out_valid", out_valid, iv_d);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    vec_t v;
                    v = exp_q.pop_front();
                    chk("s", s, v.es);
                    chk("cout", cout, v.ec);
                    chk("err", err, v.ee);
                    last_s = v.es;
                    last_c = v.ec;
                    last_e = v.ee;
                end
            end else begin
                chk("hold_s", s, last_s);
                chk("hold_cout", cout, last_c);
                chk("hold_err", err, last_e);
            end
        end
    end

    function automatic vec_t mk(input int va, input int vb, input int vc,
                                input int es, input int ec, input int ee);
        vec_t v;
        v.a = va[3:0]; v.b = vb[3:0]; v.cin = vc[0];
        v.es = es[3:0]; v.ec = ec[0]; v.ee = ee[0];
        return v;
    endfunction

    task automatic issue(input vec_t v);
        @(posedge clk);
        #1;
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = 4'hF; b = 4'hF; cin = 1'b1;
        end
    endtask

    vec_t dir[$];
    vec_t strm[$];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Directed vectors (a, b, cin, s, cout, err)
        dir.push_back(mk(1, 3, 0, 4, 0, 0));
        dir.push_back(mk(2, 1, 0, 3, 0, 0));
        dir.push_back(mk(3, 5, 1, 9, 0, 0));
        dir.push_back(mk(7, 8, 0, 5, 1, 0));
        dir.push_back(mk(4, 8, 1, 3, 1, 0));
        dir.push_back(mk(2, 8, 0, 0, 1, 0));
        dir.push_back(mk(4, 6, 0, 0, 1, 0));
        dir.push_back(mk(9, 9, 0, 8, 1, 0));
        dir.push_back(mk(9, 9, 1, 9, 1, 0));
        dir.push_back(mk(0, 0, 0, 0, 0, 0));
        dir.push_back(mk(9, 0, 1, 0, 1, 0));

        strm.push_back(mk(5, 5, 0, 0, 1, 0));
        strm.push_back(mk(6, 2, 1, 9, 0, 0));
        strm.push_back(mk(8, 3, 1, 2, 1, 0));
        strm.push_back(mk(0, 7, 0, 7, 0, 0));
        strm.push_back(mk(9, 6, 1, 6, 1, 0));

        // Reset state before release
        @(posedge clk);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed vectors, each followed by one idle cycle
        foreach (dir[i]) begin
            issue(dir[i]);
            idle(1);
        end

        // Back-to-back stream, then a two-cycle gap
        foreach (strm[i]) issue(strm[i]);
        idle(2);

        // Reset while out_valid is high and another result is in flight
        issue(mk(1, 1, 0, 2, 0, 0));
        issue(mk(3, 3, 0, 6, 0, 0));
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_err", err, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(1);

        // First result after release, then illegal operand
        issue(mk(4, 4, 1, 9, 0, 0));
`ifdef BCD_INPUT_CHECK_EN
        issue(mk(12, 3, 0, 0, 0, 1));
        issue(mk(15, 15, 1, 0, 0, 1));
`else
        issue(mk(12, 3, 0, 5, 1, 0));
        issue(mk(15, 15, 1, 5, 1, 0));
`endif
        issue(mk(2, 2, 0, 4, 0, 0));
        idle(3);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule

// File: doc/single_digit_decimal_adder.md
Name: single_digit_decimal_adder

Overview:
- Single-digit BCD (decimal) adder: adds two BCD digits plus carry-in and produces a BCD sum digit and a decimal carry-out.
- Building block for multi-digit decimal adders: chain cout of one digit to cin of the next.
- Synchronous wrapper around the combinational BCD add, with a valid qualifier and an optional input-legality check.

Parameters:
- REG_OUT, 1. 1 = outputs registered (1-cycle latency). 0 = outputs combinational from inputs (0 latency; clk/rst_n affect nothing).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a/b/cin are valid this cycle
- a  input  4  BCD addend digit, 0..9
- b  input  4  BCD addend digit, 0..9
- cin  input  1  decimal carry-in
- out_valid  output  1  s/cout/err valid
- s  output  4  BCD sum digit, 0..9
- cout  output  1  decimal carry-out (sum ≥ 10)
- err  output  1  illegal BCD input flag (see Optional Feature)

Behaviour:
- Reset: clock and reset fixed as one clock (clk), reset asynchronous active-low (rst_n).
- On rst_n=0, immediately: out_valid=0, s=0, cout=0, err=0. Held until rst_n rises.
- Raw sum: t = a + b + cin, computed 5 bits wide (range 0..19 for legal inputs).
- If t ≤ 9: s = t[3:0], cout = 0.
- If t ≥ 10: s = (t + 6)[3:0] (equivalently t − 10), cout = 1.
- REG_OUT=1:
  - On each rising clk edge, out_valid <= in_valid.
  - When in_valid=1, s/cout/err are updated from the current inputs.
  - When in_valid=0, s/cout/err hold their previous values.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle; no backpressure.
- REG_OUT=0: out_valid = in_valid, and s/cout/err are pure combinational functions of the inputs.
- Reset mid-operation: any in-flight result is discarded. The first valid result after reset release is the first in_valid sampled after release.
- Boundary cases:
  - 9+9+1 = 19 → s=9, cout=1.
  - 0+0+0 → s=0, cout=0.
  - 9+0+1 = 10 → s=0, cout=1.
- Illegal inputs (a>9 or b>9): handled per Optional Feature. With the feature absent, the same correction rule applies to t (range up to 31). s is then t+6 truncated to 4 bits, may be non-BCD, and cout=1.

Optional Feature:
- Macro: BCD_INPUT_CHECK_EN.
- Defined:
  - If in_valid=1 and (a>9 or b>9), the result is s=0, cout=0, err=1.
  - Otherwise err=0 and the normal result is produced.
  - err follows the same latency and valid qualification as s.
- Undefined:
  - No check logic is present; err is tied to 0.
  - Illegal inputs use the raw correction rule from Behaviour.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid, s, cout, err all go to 0 immediately, before the next clk edge.
- Basic no-carry: a=1, b=3, cin=0 → s=4, cout=0. a=2, b=1, cin=0 → s=3, cout=0. a=3, b=5, cin=1 → s=9, cout=0. All one cycle after in_valid.
- Decimal correction: a=7, b=8, cin=0 → s=5, cout=1. a=4, b=8, cin=1 → s=3, cout=1. a=2, b=8, cin=0 → s=0, cout=1. a=4, b=6, cin=0 → s=0, cout=1.
- Extremes: a=9, b=9, cin=0 → s=8, cout=1. a=9, b=9, cin=1 → s=9, cout=1. a=0, b=0, cin=0 → s=0, cout=0.
- Streaming: apply a new legal input every cycle with in_valid=1, then drop in_valid for 2 cycles → out_valid tracks in_valid delayed by 1, and s/cout hold their last values during the gap.
- Illegal input: a=12, b=3, cin=0.
  - With BCD_INPUT_CHECK_EN: s=0, cout=0, err=1.
  - Without it: s=5 (t=15, 15+6=21, 21 mod 16=5), cout=1, err=0.
